// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the input debouncer and its neighbouring
// edge-detector stages. The edge-detector benches reuse the same defaults.
package debounce_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int GLITCH_W_DEF        = 8;

    // Per-cycle decision taken by the stability counter.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,   // nothing pending, or logic disabled
        ACT_ABORT = 2'd1,   // input returned to dout before the window closed
        ACT_COUNT = 2'd2,   // disagreement continues, window still open
        ACT_FLIP  = 2'd3    // disagreement lasted the full window
    } deb_act_t;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2_min1(input int value);
        int w_v;
        w_v = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                w_v = i + 1;
            end else begin
                w_v = w_v;
            end
        end
        if (w_v < 1) begin
            w_v = 1;
        end else begin
            w_v = w_v;
        end
        return w_v;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level. Resets to 0.
// Reusable by any stage that needs to bring a raw pin into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync1_r;
    logic sync2_r;

    // Shift the raw level through two flops; runs every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= d;
            sync2_r <= sync1_r;
        end
    end

    assign q = sync2_r;

endmodule

// File: rtl/input_debouncer.sv
// Input debouncer: synchronises a raw level and only lets dout follow it once
// the synchronised value has disagreed with dout for DEBOUNCE_CYCLES
// consecutive enabled clocks. dout feeds the edge detectors' jj input.
// Optional feature macro: GLITCH_COUNT_EN (saturating count of aborted
// transitions on glitch_cnt; when undefined glitch_cnt is tied to zero).
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int GLITCH_W        = GLITCH_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din,
    input  logic                enable,
    output logic                dout,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int             CNT_W    = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync2_s;
    logic             diff_s;
    deb_act_t         act_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             dout_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             dout_r;
    logic             busy_r;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (sync2_s)
    );

    // Decide what the stability counter does this cycle and derive next state.
    always_comb begin
        diff_s     = sync2_s ^ dout_r;
        act_s      = ACT_HOLD;
        cnt_nxt_s  = cnt_r;
        dout_nxt_s = dout_r;

        if (!enable) begin
            act_s = ACT_HOLD;
        end else if (!diff_s) begin
            act_s = (cnt_r != CNT_ZERO) ? ACT_ABORT : ACT_HOLD;
        end else begin
            act_s = (cnt_r == CNT_LAST) ? ACT_FLIP : ACT_COUNT;
        end

        case (act_s)
            ACT_HOLD: begin
                cnt_nxt_s  = cnt_r;
                dout_nxt_s = dout_r;
            end
            ACT_ABORT: begin
                cnt_nxt_s  = CNT_ZERO;
                dout_nxt_s = dout_r;
            end
            ACT_COUNT: begin
                cnt_nxt_s  = cnt_r + CNT_ONE;
                dout_nxt_s = dout_r;
            end
            ACT_FLIP: begin
                cnt_nxt_s  = CNT_ZERO;
                dout_nxt_s = sync2_s;
            end
            default: begin
                cnt_nxt_s  = cnt_r;
                dout_nxt_s = dout_r;
            end
        endcase
    end

    // Stability counter, debounced level and pending flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= CNT_ZERO;
            dout_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            dout_r <= dout_nxt_s;
            busy_r <= (cnt_nxt_s != CNT_ZERO);
        end
    end

    assign dout = dout_r;
    assign busy = busy_r;

`ifdef GLITCH_COUNT_EN
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};
    localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

    logic [GLITCH_W-1:0] glitch_r;

    // Count aborted transitions, saturating at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_r <= {GLITCH_W{1'b0}};
        end else if ((act_s == ACT_ABORT) && (glitch_r != GLITCH_MAX)) begin
            glitch_r <= glitch_r + GLITCH_ONE;
        end else begin
            glitch_r <= glitch_r;
        end
    end

    assign glitch_cnt = glitch_r;
`else
    assign glitch_cnt = {GLITCH_W{1'b0}};
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed, table-driven bench for input_debouncer (N=4, GLITCH_W=8).
// Build with GLITCH_COUNT_EN defined to also exercise the glitch counter.
module tb_input_debouncer;

    localparam int N  = 4;
    localparam int GW = 8;
`ifdef GLITCH_COUNT_EN
    localparam bit GL_ON = 1'b1;
`else
    localparam bit GL_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          din;
    logic          enable;
    logic          dout;
    logic          busy;
    logic [GW-1:0] glitch_cnt;

    int total;
    int bad;

    typedef struct {
        bit rst;
        bit en;
        bit din;
        bit exp_dout;
        bit exp_busy;
        int exp_glitch;
    } vec_t;

    vec_t vec_q[$];

    input_debouncer #(.DEBOUNCE_CYCLES(N), .GLITCH_W(GW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .enable     (enable),
        .dout       (dout),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #85 clk = ~clk;

    task automatic add(input int n, input bit r, input bit e, input bit d,
                       input bit xd, input bit xb, input int xg);
        vec_t v;
        v.rst = r; v.en = e; v.din = d;
        v.exp_dout = xd; v.exp_busy = xb; v.exp_glitch = xg;
        for (int k = 0; k < n; k++) vec_q.push_back(v);
    endtask

    task automatic check(input string nm, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit d);
        rst = r; enable = e; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g1;
        int exp_g;
        total = 0;
        bad   = 0;
        g1    = GL_ON ? 1 : 0;
        rst = 1'b1; enable = 1'b1; din = 1'b1;

        // 1: reset with din=1, then release: dout rises after edge 6
        add(2, 1, 1, 1, 0, 0, 0);
        add(2, 0, 1, 1, 0, 0, 0);
        add(3, 0, 1, 1, 0, 1, 0);
        add(1, 0, 1, 1, 1, 0, 0);
        // fall back to 0
        add(2, 0, 1, 0, 1, 0, 0);
        add(3, 0, 1, 0, 1, 1, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        // 3: two-clock pulse is rejected, aborted at edge 5
        add(2, 0, 1, 1, 0, 0, 0);
        add(2, 0, 1, 0, 0, 1, 0);
        add(2, 0, 1, 0, 0, 0, g1);
        // 2: clean rise, busy on edges 3..5, dout at edge 6
        add(2, 0, 1, 1, 0, 0, g1);
        add(3, 0, 1, 1, 0, 1, g1);
        add(2, 0, 1, 1, 1, 0, g1);
        // fall again to set up enable test
        add(2, 0, 1, 0, 1, 0, g1);
        add(3, 0, 1, 0, 1, 1, g1);
        add(1, 0, 1, 0, 0, 0, g1);
        // 4: rise, freeze at cnt=2 for 5 clocks, then finish two edges later
        add(2, 0, 1, 1, 0, 0, g1);
        add(2, 0, 1, 1, 0, 1, g1);
        add(5, 0, 0, 1, 0, 1, g1);
        add(1, 0, 1, 1, 0, 1, g1);
        add(1, 0, 1, 1, 1, 0, g1);
        // 5: fall pending to cnt=3, reset mid-count, din back to 1
        add(2, 0, 1, 0, 1, 0, g1);
        add(3, 0, 1, 0, 1, 1, g1);
        add(1, 1, 1, 1, 0, 0, 0);
        add(2, 0, 1, 1, 0, 0, 0);
        add(3, 0, 1, 1, 0, 1, 0);
        add(1, 0, 1, 1, 1, 0, 0);

        for (int i = 0; i < vec_q.size(); i++) begin
            step(vec_q[i].rst, vec_q[i].en, vec_q[i].din);
            check("dout", i, {31'd0, dout}, {31'd0, vec_q[i].exp_dout});
            check("busy", i, {31'd0, busy}, {31'd0, vec_q[i].exp_busy});
            check("glitch_cnt", i, {24'd0, glitch_cnt}, vec_q[i].exp_glitch);
        end

        // 6: 300 one-clock low glitches against dout=1; counter saturates
        for (int g = 1; g <= 300; g++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b1, 1'b1);
            check("glitch_busy", g, {31'd0, busy}, 32'd1);
            step(1'b0, 1'b1, 1'b1);
            exp_g = GL_ON ? ((g > 255) ? 255 : g) : 0;
            check("glitch_dout", g, {31'd0, dout}, 32'd1);
            check("glitch_sat", g, {24'd0, glitch_cnt}, exp_g);
        end
        check("glitch_idle", 0, {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
